// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master byte controller and its gap timer.
package spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_READ,
    ST_DONE,
    ST_GAP
  } state_e;

  localparam int BITS_PER_FRAME = 8;
  localparam int FRAME_OVERHEAD = 3;

endpackage

// File: rtl/spi_gap_timer.sv
// Loadable down-counter with a zero flag; it times the GAP state between frames.
module spi_gap_timer (
  input  logic       clk_i,
  input  logic       clr_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  output logic       zero_o
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      cnt_q <= 4'd0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign zero_o = (cnt_q == 4'd0);

endmodule

// File: rtl/spi_master_ctrl.sv
// Byte transaction controller driving an SPI sender/receiver pair.
// Receive path (capture, RX_VALID, R_RE/R_READ, R_FULL check) enabled by `define SPI_MASTER_RX_EN.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int BIT_COUNT  = BITS_PER_FRAME
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       ERR,
  output logic       BUSY,
  output logic       SS_N,
  output logic [7:0] S_DATA,
  output logic       S_WRITE,
  output logic       S_TE,
  input  logic       S_EMPTY,
  output logic       R_READ,
  output logic       R_RE,
  input  logic       R_FULL,
  input  logic [7:0] R_DATA,
  output state_e     STATE_DBG
);

`ifdef SPI_MASTER_RX_EN
  localparam logic RX_EN = 1'b1;
`else
  localparam logic RX_EN = 1'b0;
`endif

  localparam logic [3:0] LAST_BIT = 4'(BIT_COUNT - 1);
  // The accepting IDLE cycle is the last gap cycle, so GAP itself lasts GAP_CYCLES-1 cycles.
  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES >= 2) ? 4'(GAP_CYCLES - 2) : 4'd0;

  // Handshake: a byte moves on the rising edge where TX_VALID && TX_READY are both high.
  state_e     state_q;
  logic [3:0] bit_cnt_q;
  logic [7:0] s_data_q, rx_data_q;
  logic       tx_ready_q, rx_valid_q, err_q, busy_q, ss_n_q;
  logic       s_write_q, s_te_q, r_read_q, r_re_q;
  logic       gap_load, gap_zero;

  assign gap_load = (state_q == ST_DONE) && (GAP_CYCLES >= 2);

  spi_gap_timer u_gap_timer (
    .clk_i      (CLK),
    .clr_i      (CLR),
    .load_i     (gap_load),
    .load_val_i (GAP_LOAD),
    .zero_o     (gap_zero)
  );

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 4'd0;
      s_data_q   <= 8'd0;
      rx_data_q  <= 8'd0;
      tx_ready_q <= 1'b1;
      rx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      s_write_q  <= 1'b0;
      s_te_q     <= 1'b0;
      r_read_q   <= 1'b0;
      r_re_q     <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (TX_VALID && tx_ready_q) begin
            state_q    <= ST_LOAD;
            s_data_q   <= TX_DATA;
            bit_cnt_q  <= 4'd0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            ss_n_q     <= 1'b0;
            s_write_q  <= 1'b1;
            r_read_q   <= RX_EN;
          end else begin
            tx_ready_q <= gap_zero;
          end
        end
        ST_LOAD: begin
          state_q   <= ST_SHIFT;
          s_write_q <= 1'b0;
          r_read_q  <= 1'b0;
          s_te_q    <= 1'b1;
          r_re_q    <= RX_EN;
        end
        ST_SHIFT: begin
          bit_cnt_q <= bit_cnt_q + 4'd1;
          if (bit_cnt_q == LAST_BIT) begin
            state_q  <= ST_READ;
            s_te_q   <= 1'b0;
            r_re_q   <= 1'b0;
            r_read_q <= RX_EN;
          end
        end
        ST_READ: begin
          state_q    <= ST_DONE;
          r_read_q   <= 1'b0;
          ss_n_q     <= 1'b1;
          rx_valid_q <= RX_EN;
          if (RX_EN) begin
            rx_data_q <= R_DATA;
          end
          if (!S_EMPTY || (RX_EN && !R_FULL)) begin
            err_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (GAP_CYCLES <= 1) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b1;
          end else begin
            state_q <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_zero) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign TX_READY  = tx_ready_q;
  assign RX_DATA   = rx_data_q;
  assign RX_VALID  = rx_valid_q;
  assign ERR       = err_q;
  assign BUSY      = busy_q;
  assign SS_N      = ss_n_q;
  assign S_DATA    = s_data_q;
  assign S_WRITE   = s_write_q;
  assign S_TE      = s_te_q;
  assign R_READ    = r_read_q;
  assign R_RE      = r_re_q;
  assign STATE_DBG = state_q;

endmodule
